// File: rtl/uart_rx_pkg.sv
// ----------------------------------------------------------------------------
// uart_rx_pkg
//   Shared definitions for the board UART receive path: default line settings,
//   the receiver FSM state encoding and a helper that derives the baud divider.
//   Imported by uart_rx and usable by the TX side so both agree on defaults.
// ----------------------------------------------------------------------------
package uart_rx_pkg;

   // Board oscillator and the host link rate
   localparam int DEFAULT_CLK_FREQ  = 27_000_000;
   localparam int DEFAULT_BAUD      = 115_200;
   localparam int DEFAULT_DATA_BITS = 8;

   // Receiver FSM states; BREAK parks a held-low line so it reports only once
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP,
      ST_BREAK
   } rx_state_t;

   // Whole system clocks per serial bit (truncating division)
   function automatic int clks_per_bit(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// ----------------------------------------------------------------------------
// uart_rx_sync_2ff
//   Two-flop synchronizer for a single asynchronous input bit. The reset value
//   is a parameter so idle-high lines (UART RX) and idle-low lines (cmos_*)
//   can both come out of reset in their idle level.
// Ports
//   clock  in   1  destination clock
//   reset  in   1  asynchronous, active-high reset
//   d      in   1  asynchronous input
//   q      out  1  synchronized output, two clocks of latency
// ----------------------------------------------------------------------------
module uart_rx_sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   // First flop may go metastable; the second gives it a full cycle to settle
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx
//   Serial receiver (8N1 by default) for the debug/control link. Samples the
//   raw RX pin after a 2-flop synchronizer, checks start and stop bits at
//   mid-bit and hands each byte over through a 1-entry valid/ready holding
//   register. Framing errors and overruns are reported as 1-cycle pulses.
// Ports
//   I_clk        in   1          system clock, posedge
//   I_rst        in   1          asynchronous, active-high reset
//   I_rx         in   1          raw serial line, idle high
//   O_data       out  DATA_BITS  received byte, stable while O_valid=1
//   O_valid      out  1          byte waiting in holding register
//   I_ready      in   1          consumer takes the byte when O_valid&I_ready
//   O_frame_err  out  1          pulse: stop bit sampled low
//   O_overrun    out  1          pulse: new byte dropped, holding reg full
//   O_busy       out  1          frame in progress
// ----------------------------------------------------------------------------
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLK_FREQ  = DEFAULT_CLK_FREQ,
   parameter int BAUD      = DEFAULT_BAUD,
   parameter int DATA_BITS = DEFAULT_DATA_BITS
) (
   input  logic                 I_clk,
   input  logic                 I_rst,
   input  logic                 I_rx,
   output logic [DATA_BITS-1:0] O_data,
   output logic                 O_valid,
   input  logic                 I_ready,
   output logic                 O_frame_err,
   output logic                 O_overrun,
   output logic                 O_busy
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CNT_W-1:0] CNT_HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST      = IDX_W'(DATA_BITS - 1);

   logic                 rx_s;
   rx_state_t            state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [IDX_W-1:0]     idx_q, idx_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [DATA_BITS-1:0] data_q, data_d;
   logic                 valid_q, valid_d;
   logic                 frame_err_q, frame_err_d;
   logic                 overrun_q, overrun_d;

   // The line idles high, so the synchronizer resets to 1 to avoid a fake start bit
   uart_rx_sync_2ff #(.RESET_VAL(1'b1)) u_sync (
      .clock (I_clk),
      .reset (I_rst),
      .d     (I_rx),
      .q     (rx_s)
   );

   // State and datapath registers; reset drops any partial frame on the floor
   always_ff @(posedge I_clk or posedge I_rst) begin
      if (I_rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   // Next-state logic. The start bit is checked at half a bit, which puts
   // every later sample (data and stop) one full bit apart at mid-bit. A good
   // stop bit returns to IDLE right away so the back half of the stop bit
   // counts as idle time and back-to-back frames are not missed.
   // The holding register clears on accept unless a new byte loads the same cycle.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      data_d      = data_q;
      valid_d     = valid_q & ~I_ready;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            if (!rx_s) state_d = ST_START;
         end
         ST_START: begin
            if (cnt_q == CNT_HALF_LAST) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rx_s ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d   = '0;
               shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
               idx_d   = idx_q + IDX_W'(1);
               if (idx_q == IDX_LAST) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_BIT_LAST) begin
               cnt_d = '0;
               if (rx_s) begin
                  state_d = ST_IDLE;
                  if (!valid_q || I_ready) begin
                     data_d  = shift_q;
                     valid_d = 1'b1;
                  end else begin
                     overrun_d = 1'b1;
                  end
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = ST_BREAK;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_BREAK: begin
            cnt_d = '0;
            if (rx_s) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign O_data      = data_q;
   assign O_valid     = valid_q;
   assign O_frame_err = frame_err_q;
   assign O_overrun   = overrun_q;
   assign O_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx at 27 MHz / 115200 baud. A bit-timed
//   sender drives the line; a negedge monitor logs accepted bytes and pulses;
//   a transaction-level model of the holding register predicts the results.
// ----------------------------------------------------------------------------
module tb_uart_rx;

   localparam int CPB = 27_000_000 / 115_200;

   logic       I_clk = 1'b0;
   logic       I_rst;
   logic       I_rx;
   logic       I_ready;
   logic [7:0] O_data;
   logic       O_valid;
   logic       O_frame_err;
   logic       O_overrun;
   logic       O_busy;

   int checks   = 0;
   int failures = 0;
   int cycle    = 0;

   // Monitor observations
   logic [7:0] got_q[$];
   int         ferr_cnt = 0;
   int         ovr_cnt = 0;
   int         rise_cnt = 0;
   int         last_rise_cycle = 0;
   logic       prev_valid = 1'b0;

   // Reference model: what the consumer should see at byte level
   logic [7:0] exp_q[$];
   logic       exp_hold_valid = 1'b0;
   logic [7:0] exp_hold_data = 8'h00;
   int         exp_ferr = 0;
   int         exp_ovr = 0;

   uart_rx #(
      .CLK_FREQ  (27_000_000),
      .BAUD      (115_200),
      .DATA_BITS (8)
   ) dut (
      .I_clk       (I_clk),
      .I_rst       (I_rst),
      .I_rx        (I_rx),
      .O_data      (O_data),
      .O_valid     (O_valid),
      .I_ready     (I_ready),
      .O_frame_err (O_frame_err),
      .O_overrun   (O_overrun),
      .O_busy      (O_busy)
   );

   // Free-running clock and cycle counter
   always #5 I_clk = ~I_clk;

   always @(posedge I_clk) cycle++;

   // Sample outputs mid-cycle, well away from the active edge
   always @(negedge I_clk) begin
      if (I_rst) begin
         prev_valid = 1'b0;
      end else begin
         if (O_valid && !prev_valid) begin
            rise_cnt++;
            last_rise_cycle = cycle;
         end
         if (O_valid && I_ready) got_q.push_back(O_data);
         if (O_frame_err) ferr_cnt++;
         if (O_overrun) ovr_cnt++;
         prev_valid = O_valid;
      end
   end

   // All stimulus tasks begin and end 1 time unit after a rising edge
   task automatic drive_bit(input logic v, input int n);
      I_rx = v;
      repeat (n) @(posedge I_clk);
      #1;
   endtask

   task automatic idle_cycles(input int n);
      drive_bit(1'b1, n);
   endtask

   task automatic send_frame(input logic [7:0] b, input int cpb, input logic stop_v);
      drive_bit(1'b0, cpb);
      for (int i = 0; i < 8; i++) drive_bit(b[i], cpb);
      drive_bit(stop_v, cpb);
      I_rx = 1'b1;
   endtask

   task automatic clear_monitor();
      got_q.delete();
      exp_q.delete();
      ferr_cnt = 0;
      ovr_cnt  = 0;
      rise_cnt = 0;
      exp_ferr = 0;
      exp_ovr  = 0;
   endtask

   // Byte-level behaviour of one received frame with a steady ready level
   task automatic applyStimulus(input logic [7:0] b, input logic stop_ok, input logic ready);
      if (!stop_ok) begin
         exp_ferr++;
      end else if (exp_hold_valid && !ready) begin
         exp_ovr++;
      end else begin
         if (exp_hold_valid) exp_q.push_back(exp_hold_data);
         exp_hold_data  = b;
         exp_hold_valid = 1'b1;
      end
      if (ready && exp_hold_valid) begin
         exp_q.push_back(exp_hold_data);
         exp_hold_valid = 1'b0;
      end
   endtask

   task automatic test_reset();
      I_rst   = 1'b1;
      I_rx    = 1'b1;
      I_ready = 1'b0;
      repeat (3) @(posedge I_clk);
      @(negedge I_clk);
      checks++;
      if ({O_valid, O_frame_err, O_overrun, O_busy, O_data} !== 12'h000) begin
         failures++;
         $display("[TB] FAIL reset_outputs: got %h expected 000",
                  {O_valid, O_frame_err, O_overrun, O_busy, O_data});
      end
      @(posedge I_clk);
      #1;
      I_rst = 1'b0;
      idle_cycles(20);
   endtask

   task automatic test_single_frame();
      int start_cyc;
      int exp_lat;
      clear_monitor();
      I_ready   = 1'b1;
      start_cyc = cycle;
      exp_lat   = ((2 * 8 + 3) * CPB) / 2 + 3;
      send_frame(8'hA5, CPB, 1'b1);
      applyStimulus(8'hA5, 1'b1, 1'b1);
      idle_cycles(20);
      checks++;
      if (got_q.size() != 1 || got_q[0] !== 8'hA5) begin
         failures++;
         $display("[TB] FAIL single_byte: got %0d bytes first %h expected 1 byte a5",
                  got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx);
      end
      checks++;
      if (rise_cnt != 1 || ferr_cnt != 0 || ovr_cnt != 0) begin
         failures++;
         $display("[TB] FAIL single_pulses: got valid=%0d ferr=%0d ovr=%0d expected 1/0/0",
                  rise_cnt, ferr_cnt, ovr_cnt);
      end
      checks++;
      if ((last_rise_cycle - start_cyc) < exp_lat - 2 || (last_rise_cycle - start_cyc) > exp_lat + 2) begin
         failures++;
         $display("[TB] FAIL single_latency: got %0d expected %0d +/-2",
                  last_rise_cycle - start_cyc, exp_lat);
      end
   endtask

   task automatic test_back_to_back_overrun();
      clear_monitor();
      I_ready = 1'b0;
      send_frame(8'h3C, CPB, 1'b1);
      applyStimulus(8'h3C, 1'b1, 1'b0);
      send_frame(8'hC3, CPB, 1'b1);
      applyStimulus(8'hC3, 1'b1, 1'b0);
      idle_cycles(20);
      @(negedge I_clk);
      checks++;
      if (O_valid !== exp_hold_valid || O_data !== exp_hold_data) begin
         failures++;
         $display("[TB] FAIL overrun_hold: got valid=%b data=%h expected valid=%b data=%h",
                  O_valid, O_data, exp_hold_valid, exp_hold_data);
      end
      checks++;
      if (ovr_cnt != exp_ovr || ferr_cnt != exp_ferr || got_q.size() != 0) begin
         failures++;
         $display("[TB] FAIL overrun_count: got ovr=%0d ferr=%0d acc=%0d expected ovr=%0d ferr=%0d acc=0",
                  ovr_cnt, ferr_cnt, got_q.size(), exp_ovr, exp_ferr);
      end
      @(posedge I_clk);
      #1;
      I_ready = 1'b1;
      if (exp_hold_valid) begin
         exp_q.push_back(exp_hold_data);
         exp_hold_valid = 1'b0;
      end
      @(posedge I_clk);
      #1;
      I_ready = 1'b0;
      @(negedge I_clk);
      checks++;
      if (O_valid !== exp_hold_valid) begin
         failures++;
         $display("[TB] FAIL overrun_release: got valid=%b expected %b", O_valid, exp_hold_valid);
      end
      checks++;
      if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("[TB] FAIL overrun_accept: got %0d bytes expected %0d, first expected %h",
                  got_q.size(), exp_q.size(), exp_q[0]);
      end
      @(posedge I_clk);
      #1;
   endtask

   task automatic test_glitch();
      clear_monitor();
      I_ready = 1'b1;
      drive_bit(1'b0, 40);
      @(negedge I_clk);
      checks++;
      if (O_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL glitch_busy: got %b expected 1", O_busy);
      end
      @(posedge I_clk);
      #1;
      drive_bit(1'b0, 9);
      idle_cycles(300);
      checks++;
      if (rise_cnt != 0 || ferr_cnt != 0 || O_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL glitch_ignored: got valid=%0d ferr=%0d busy=%b expected 0/0/0",
                  rise_cnt, ferr_cnt, O_busy);
      end
   endtask

   task automatic test_frame_error();
      clear_monitor();
      I_ready = 1'b1;
      drive_bit(1'b0, CPB);
      for (int i = 0; i < 8; i++) drive_bit(1'(8'h55 >> i), CPB);
      drive_bit(1'b0, 20 * CPB);
      applyStimulus(8'h55, 1'b0, 1'b1);
      idle_cycles(50);
      checks++;
      if (ferr_cnt != exp_ferr || rise_cnt != 0 || O_busy !== 1'b0) begin
         failures++;
         $display("[TB] FAIL frame_err_once: got ferr=%0d valid=%0d busy=%b expected %0d/0/0",
                  ferr_cnt, rise_cnt, O_busy, exp_ferr);
      end
      send_frame(8'h81, CPB, 1'b1);
      applyStimulus(8'h81, 1'b1, 1'b1);
      idle_cycles(20);
      checks++;
      if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0]) begin
         failures++;
         $display("[TB] FAIL frame_err_recover: got %0d bytes expected %0d (%h)",
                  got_q.size(), exp_q.size(), exp_q[0]);
      end
   endtask

   task automatic test_reset_mid_frame();
      clear_monitor();
      I_ready = 1'b1;
      for (int i = 0; i < 4; i++) drive_bit(1'b0, CPB);
      drive_bit(1'b0, CPB / 2);
      @(negedge I_clk);
      checks++;
      if (O_busy !== 1'b1) begin
         failures++;
         $display("[TB] FAIL midreset_busy: got %b expected 1", O_busy);
      end
      @(posedge I_clk);
      #1;
      I_rst = 1'b1;
      I_rx  = 1'b1;
      exp_hold_valid = 1'b0;
      @(negedge I_clk);
      checks++;
      if ({O_valid, O_frame_err, O_overrun, O_busy, O_data} !== 12'h000) begin
         failures++;
         $display("[TB] FAIL midreset_outputs: got %h expected 000",
                  {O_valid, O_frame_err, O_overrun, O_busy, O_data});
      end
      @(posedge I_clk);
      #1;
      I_rst = 1'b0;
      idle_cycles(20);
      send_frame(8'h7E, CPB, 1'b1);
      applyStimulus(8'h7E, 1'b1, 1'b1);
      idle_cycles(20);
      checks++;
      if (got_q.size() != exp_q.size() || got_q[0] !== exp_q[0] || ferr_cnt != 0) begin
         failures++;
         $display("[TB] FAIL midreset_recover: got %0d bytes ferr=%0d expected %0d (%h) ferr=0",
                  got_q.size(), ferr_cnt, exp_q.size(), exp_q[0]);
      end
   endtask

   // Sender clock off by +3% (fewer clocks per bit) and -3% (more)
   task automatic test_baud_tolerance();
      int cpb_list[2];
      logic [7:0] byte_list[2];
      clear_monitor();
      I_ready      = 1'b1;
      cpb_list[0]  = (CPB * 100) / 103;
      cpb_list[1]  = (CPB * 103) / 100;
      byte_list[0] = 8'h00;
      byte_list[1] = 8'hFF;
      for (int c = 0; c < 2; c++) begin
         for (int b = 0; b < 2; b++) begin
            send_frame(byte_list[b], cpb_list[c], 1'b1);
            applyStimulus(byte_list[b], 1'b1, 1'b1);
         end
      end
      idle_cycles(20);
      checks++;
      if (got_q.size() != exp_q.size() || ferr_cnt != 0 || ovr_cnt != 0) begin
         failures++;
         $display("[TB] FAIL tolerance_count: got %0d bytes ferr=%0d ovr=%0d expected %0d/0/0",
                  got_q.size(), ferr_cnt, ovr_cnt, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               failures++;
               $display("[TB] FAIL tolerance_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      clear_monitor();
      I_ready = 1'b1;
      for (int n = 0; n < 5; n++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, int'($urandom_range(CPB - 4, CPB + 4)), 1'b1);
         applyStimulus(b, 1'b1, 1'b1);
         idle_cycles(int'($urandom_range(0, 30)));
      end
      idle_cycles(20);
      checks++;
      if (got_q.size() != exp_q.size() || ferr_cnt != 0 || ovr_cnt != 0) begin
         failures++;
         $display("[TB] FAIL random_count: got %0d bytes ferr=%0d ovr=%0d expected %0d/0/0",
                  got_q.size(), ferr_cnt, ovr_cnt, exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
               failures++;
               $display("[TB] FAIL random_byte%0d: got %h expected %h", i, got_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // Scenarios run in order, each leaving the line idle and the holding register empty
   initial begin
      $display("[TB] uart_rx bench start, %0d clocks per bit", CPB);
      test_reset();
      test_single_frame();
      test_back_to_back_overrun();
      test_glitch();
      test_frame_error();
      test_reset_mid_frame();
      test_baud_tolerance();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
